fifo_ctrl: RTL and testbench

Control stage for the register-file FIFO: tracks write and read pointers, generates the write enable and the write/read addresses that drive the FIFO register file, and reports occupancy status (empty, full, count, almost-full/empty) plus sticky overflow/underflow errors. Sits between the producer/consumer handshakes (`wr`/`rd`) and the FIFO storage array. Together with the register file it forms the complete synchronous FIFO used by the UART and other buffered peripherals.

---
 rtl/fifo_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a register-file FIFO: produces write strobe,
// write/read addresses, occupancy flags and sticky overflow/underflow errors.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  do_wr, do_rd;

  // A write into a full FIFO is still legal when a pop frees the head slot.
  always_comb begin
    do_wr       = wr & (~full_q | rd);
    do_rd       = rd & ~empty_q;
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    empty_d     = empty_q;
    full_d      = full_q;
    overflow_d  = (overflow_q & ~clr_err) | (wr & full_q & ~rd);
    underflow_d = (underflow_q & ~clr_err) | (rd & empty_q);
    unique case ({do_wr, do_rd})
      2'b10: begin
        w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
        count_d = count_q + CW'(1);
        empty_d = 1'b0;
        full_d  = (w_ptr_d == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
        count_d = count_q - CW'(1);
        full_d  = 1'b0;
        empty_d = (r_ptr_d == w_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
        r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_en         = do_wr;
  assign w_addr       = w_ptr_q;
  assign r_addr       = r_ptr_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // Threshold flags are a pure decode of the registered occupancy.
  assign almost_full  = (count_q >= CW'(DEPTH - AF_MARGIN));
  assign almost_empty = (count_q <= CW'(AE_MARGIN));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (ADDR_WIDTH=3): fill, overflow, drain, underflow,
// simultaneous push/pop at mid, full and empty occupancy, and async reset.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, rd, clr_err;
  logic       w_en;
  logic [2:0] w_addr, r_addr;
  logic       empty, full;
  logic [3:0] count;
  logic       almost_full, almost_empty;
  logic       overflow, underflow;

  int vectors = 0;
  int errors  = 0;

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check the combinational strobe, then clock once and settle.
  task automatic cyc(input logic w, input logic r, input logic c, input logic exp_wen);
    wr = w; rd = r; clr_err = c;
    #1;
    chk("w_en", w_en, exp_wen);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_waddr"}, w_addr, 0);
    chk({tag, "_raddr"}, r_addr, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("rst");
    chk("rst_wen", w_en, 0);
    cyc(0, 0, 0, 0);
    chk_reset_state("idle");

    // Fill to full.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 1);
      chk("fill_count", count, i);
      chk("fill_af", almost_full, (i >= 7) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
      chk("fill_empty", empty, 0);
      chk("fill_waddr", w_addr, i % 8);
    end
    cyc(1, 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_waddr", w_addr, 0);

    // Drain to empty.
    for (int i = 0; i < 8; i++) begin
      chk("drain_raddr_pre", r_addr, i);
      cyc(0, 1, 0, 0);
      chk("drain_count", count, 7 - i);
      chk("drain_empty", empty, (i == 7) ? 1 : 0);
      chk("drain_ae", almost_empty, (7 - i <= 1) ? 1 : 0);
      chk("drain_full", full, 0);
    end
    chk("drain_raddr", r_addr, 0);
    cyc(0, 1, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_raddr", r_addr, 0);
    chk("unf_waddr", w_addr, 0);
    chk("unf_count", count, 0);
    chk("unf_ovf_held", overflow, 1);
    cyc(0, 0, 1, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // Simultaneous push/pop at count 4.
    repeat (4) cyc(1, 0, 0, 1);
    chk("mid_count0", count, 4);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 1);
    chk("mid_count", count, 4);
    chk("mid_waddr", w_addr, 6);
    chk("mid_raddr", r_addr, 2);
    chk("mid_empty", empty, 0);
    chk("mid_full", full, 0);
    chk("mid_af", almost_full, 0);
    chk("mid_ae", almost_empty, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_unf", underflow, 0);

    // Simultaneous push/pop while full.
    repeat (4) cyc(1, 0, 0, 1);
    chk("full2_full", full, 1);
    chk("full2_waddr", w_addr, 2);
    repeat (3) cyc(1, 1, 0, 1);
    chk("fullrw_count", count, 8);
    chk("fullrw_full", full, 1);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_waddr", w_addr, 5);
    chk("fullrw_raddr", r_addr, 5);
    // Overflow set wins over a coincident clear.
    cyc(1, 0, 1, 0);
    chk("ovf_vs_clr", overflow, 1);
    chk("ovf_vs_clr_count", count, 8);
    cyc(0, 0, 1, 0);
    chk("ovf_clr2", overflow, 0);

    // Simultaneous push/pop while empty: write only.
    repeat (8) cyc(0, 1, 0, 0);
    chk("empty2_empty", empty, 1);
    chk("empty2_raddr", r_addr, 5);
    cyc(1, 1, 0, 1);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_empty", empty, 0);
    chk("emptyrw_unf", underflow, 1);
    chk("emptyrw_raddr", r_addr, 5);
    chk("emptyrw_waddr", w_addr, 6);
    chk("emptyrw_ae", almost_empty, 1);
    cyc(0, 0, 1, 0);
    chk("unf_clr2", underflow, 0);

    // Asynchronous reset between edges at count 5.
    repeat (4) cyc(1, 0, 0, 1);
    chk("pre_arst_count", count, 5);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("arst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 1);
    chk("post_arst_count", count, 1);
    chk("post_arst_waddr", w_addr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
